nios2_div_cell: RTL and testbench
=================================

Name: nios2_div_cell

Overview:
- Iterative radix-2 restoring divider for the Nios II custom-instruction / A-stage datapath.
- Arithmetic companion to the pipelined multiply cell: the multiply cell computes products, this block recovers quotient and remainder.
- Accepts one operation per start handshake and returns quotient and remainder after a fixed latency.
- Supports signed and unsigned operands, matching Nios II div/divu semantics.

Parameters:
- DATA_WIDTH, 32, operand/result width; even, >= 4; iteration count = DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- A_div_start  input  1  start request; accepted only when busy=0.
- A_div_signed  input  1  1 = signed (two's complement), 0 = unsigned; sampled with start.
- A_div_src1  input  DATA_WIDTH  dividend; sampled with start.
- A_div_src2  input  DATA_WIDTH  divisor; sampled with start.
- A_div_busy  output  1  operation in progress.
- A_div_done  output  1  one-cycle pulse: results valid.
- A_div_quotient  output  DATA_WIDTH  registered quotient.
- A_div_remainder  output  DATA_WIDTH  registered remainder.

Behaviour:
- Reset (async, any state): FSM=IDLE, busy=0, done=0, quotient=0, remainder=0, iteration counter=0. An operation in flight is discarded and no done is produced.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1 at edge k:
  - Latch signed flag.
  - Latch |src1| and |src2| (abs only when signed).
  - Latch quotient sign = sign1 XOR sign2 and remainder sign = sign1.
  - Clear partial remainder and counter; go to CALC; busy=1.
- CALC, one iteration per clock:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor; if no borrow, keep the difference and shift in quotient bit 1, else shift in 0.
  - After DATA_WIDTH iterations (edge k+DATA_WIDTH), go to FIX.
- FIX, one clock:
  - Apply sign correction (negate quotient/remainder per latched signs).
  - Apply special cases.
  - Register outputs; done<=1; busy<=0; go to IDLE.
- Latency: done is high in the single cycle following edge k+DATA_WIDTH+1 (33 clocks after the accepting edge for the default). busy is high for exactly DATA_WIDTH+1 cycles.
- Start handshake:
  - start while busy=1 is ignored; no queueing.
  - start during the done cycle is accepted (busy=0 then); back-to-back throughput is one result per DATA_WIDTH+2 cycles.
- Outputs hold their last value until the next FIX, including while a new operation is busy.
- Special cases (full latency still taken):
  - Divisor = 0: quotient = all ones, remainder = src1 as sampled, in both modes.
  - Signed, src1 = most-negative, src2 = -1: quotient = most-negative (0x80000000), remainder = 0.
- Sign rules (signed mode): quotient truncates toward zero; remainder takes the dividend's sign; a zero result is never negated to a nonzero pattern.
- Width rules: partial remainder is DATA_WIDTH+1 bits internally to hold the borrow; |most-negative| is handled as an unsigned DATA_WIDTH-bit magnitude.
- Inputs are only sampled on the accepting edge; input changes during busy have no effect.

Test Plan:
- Unsigned, src1=100, src2=7, signed=0 → after 33 clocks done=1 for one cycle; quotient=14, remainder=2; busy high for exactly 33 cycles.
- Signed, src1=0xFFFFFFF9 (-7), src2=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Then src1=7, src2=0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- Divide by zero, src1=0x12345678, src2=0, both modes → quotient=0xFFFFFFFF, remainder=0x12345678, done after 33 clocks.
- Signed overflow, src1=0x80000000, src2=0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- Handshake:
  - Pulse start again at cycles 5 and 20 of a busy op with different operands → ignored; first op's results unchanged.
  - start held high through the done cycle → second op accepted, its done arrives 33 clocks later.
- Reset mid-op:
  - Assert reset at cycle 10 of CALC (asynchronously, off-edge) → busy, done, quotient, remainder go to 0 immediately; no done pulse follows.
  - After deassertion, a new op 1000/10 returns quotient=100, remainder=0.

Source files
------------

// File: rtl/nios2_div_cell.sv
// nios2_div_cell: iterative radix-2 restoring divider for the Nios II A-stage.
// One operation per start handshake; quotient and remainder are registered in
// a final fix-up cycle after DATA_WIDTH shift/subtract iterations.
// Handles both div (signed) and divu (unsigned) semantics.
module nios2_div_cell #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  A_div_start,
    input  logic                  A_div_signed,
    input  logic [DATA_WIDTH-1:0] A_div_src1,
    input  logic [DATA_WIDTH-1:0] A_div_src2,
    output logic                  A_div_busy,
    output logic                  A_div_done,
    output logic [DATA_WIDTH-1:0] A_div_quotient,
    output logic [DATA_WIDTH-1:0] A_div_remainder
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     ALL_ONES = {W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    // Two's complement negate when requested; negating zero stays zero.
    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Absolute value only in signed mode; |most-negative| is kept as an
    // unsigned W-bit magnitude, which the iteration handles directly.
    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
        return (sgn && v[W-1]) ? -v : v;
    endfunction

    // Control / architectural state (reset)
    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     quot_q, quot_d;
    logic [W-1:0]     rem_out_q, rem_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Datapath working registers (not reset; always loaded on accept)
    logic [W:0]       prem_q, prem_d;      // partial remainder, one extra bit
    logic [W-1:0]     dvd_q, dvd_d;        // dividend shifting out, quotient shifting in
    logic [W-1:0]     dvs_q, dvs_d;        // divisor magnitude
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;

    // Iteration arithmetic
    logic [W+1:0]     shifted;
    logic [W+1:0]     diff;
    logic             borrow;
    logic             sign1;
    logic             sign2;

    // Next-state, datapath and output computation
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        quot_d     = quot_q;
        rem_out_d  = rem_out_q;
        cnt_d      = cnt_q;
        prem_d     = prem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        shifted = {prem_q, dvd_q[W-1]};
        diff    = shifted - {2'b00, dvs_q};
        borrow  = diff[W+1];
        sign1   = A_div_signed & A_div_src1[W-1];
        sign2   = A_div_signed & A_div_src2[W-1];

        case (state_q)
            S_IDLE: begin
                if (A_div_start) begin
                    dvd_d      = mag(A_div_src1, A_div_signed);
                    dvs_d      = mag(A_div_src2, A_div_signed);
                    neg_quot_d = sign1 ^ sign2;
                    neg_rem_d  = sign1;
                    div_zero_d = (A_div_src2 == '0);
                    ovf_d      = A_div_signed && (A_div_src1 == MOST_NEG) &&
                                 (A_div_src2 == ALL_ONES);
                    prem_d     = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                prem_d = borrow ? shifted[W:0] : diff[W:0];
                dvd_d  = {dvd_q[W-2:0], ~borrow};
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (div_zero_q) begin
                    // Divisor magnitude 0 leaves |src1| in the remainder;
                    // re-applying the dividend sign restores src1 exactly.
                    quot_d    = ALL_ONES;
                    rem_out_d = cond_neg(prem_q[W-1:0], neg_rem_q);
                end else if (ovf_q) begin
                    quot_d    = MOST_NEG;
                    rem_out_d = '0;
                end else begin
                    quot_d    = cond_neg(dvd_q, neg_quot_q);
                    rem_out_d = cond_neg(prem_q[W-1:0], neg_rem_q);
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and result registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_out_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_out_q <= rem_out_d;
            cnt_q     <= cnt_d;
        end
    end

    // Datapath working registers
    always_ff @(posedge clk) begin
        prem_q     <= prem_d;
        dvd_q      <= dvd_d;
        dvs_q      <= dvs_d;
        neg_quot_q <= neg_quot_d;
        neg_rem_q  <= neg_rem_d;
        div_zero_q <= div_zero_d;
        ovf_q      <= ovf_d;
    end

    assign A_div_busy      = busy_q;
    assign A_div_done      = done_q;
    assign A_div_quotient  = quot_q;
    assign A_div_remainder = rem_out_q;

endmodule

// File: tb/tb_nios2_div_cell.sv
// Testbench for nios2_div_cell: directed and randomized div/divu operations
// against an arithmetic reference model, plus handshake and reset scenarios.
module tb_nios2_div_cell;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sgn;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_cmp = 0;
    int n_bad = 0;

    nios2_div_cell #(.DATA_WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .A_div_start     (start),
        .A_div_signed    (sgn),
        .A_div_src1      (src1),
        .A_div_src2      (src2),
        .A_div_busy      (busy),
        .A_div_done      (done),
        .A_div_quotient  (quotient),
        .A_div_remainder (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    // Reference: plain integer division with Nios II div/divu semantics.
    function automatic void model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, sq, sr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[W-1:0];
            r  = sr[W-1:0];
        end
    endfunction

    // Issue one operation from idle and wait (bounded) for done.
    task automatic do_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int lat, output int bcyc);
        @(negedge clk);
        sgn = s; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bcyc = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcyc++;
        end
        q = quotient;
        r = remainder;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h, want all 0", busy, done, quotient, remainder);
        end
        @(negedge clk); reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder} !== '0) begin
            n_bad++;
            $display("FAIL reset_release: busy=%b done=%b q=%h r=%h, want all 0", busy, done, quotient, remainder);
        end
    endtask

    task automatic test_directed();
        vec_t v[7];
        logic [W-1:0] q, r;
        int lat, bcyc;
        v[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
        v[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        v[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        v[3] = '{1'b0, 32'h12345678,   32'd0,        32'hFFFFFFFF, 32'h12345678};
        v[4] = '{1'b1, 32'h12345678,   32'd0,        32'hFFFFFFFF, 32'h12345678};
        v[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0};
        v[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0};
        for (int i = 0; i < 7; i++) begin
            do_op(v[i].s, v[i].a, v[i].b, q, r, lat, bcyc);
            n_cmp++;
            if (q !== v[i].q) begin
                n_bad++;
                $display("FAIL dir%0d_quot: got %h want %h", i, q, v[i].q);
            end
            n_cmp++;
            if (r !== v[i].r) begin
                n_bad++;
                $display("FAIL dir%0d_rem: got %h want %h", i, r, v[i].r);
            end
            n_cmp++;
            if (lat !== LAT) begin
                n_bad++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT);
            end
            n_cmp++;
            if (bcyc !== LAT) begin
                n_bad++;
                $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bcyc, LAT);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL dir%0d_done_pulse: done=%b one cycle later, want 0", i, done);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        bit s;
        int lat, bcyc;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = $urandom_range(1, 15);
                1:       b = '0;
                2:       b = '1;
                default: b = $urandom >> $urandom_range(0, 28);
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            model(s, a, b, eq, er);
            do_op(s, a, b, q, r, lat, bcyc);
            n_cmp++;
            if (q !== eq || r !== er || lat !== LAT) begin
                n_bad++;
                $display("FAIL rand%0d: s=%0d %h/%h got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                         i, s, a, b, q, r, lat, eq, er, LAT);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] eq, er;
        int lat, extra;
        model(1'b0, 32'd1000000, 32'd37, eq, er);
        @(negedge clk);
        sgn = 1'b0; src1 = 32'd1000000; src2 = 32'd37; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (lat == 5 || lat == 20) begin
                start = 1'b1; sgn = 1'b1; src1 = 32'hFFFF0000 + lat; src2 = 32'd3;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (quotient !== eq || remainder !== er) begin
            n_bad++;
            $display("FAIL ignore_start_result: got q=%h r=%h want q=%h r=%h", quotient, remainder, eq, er);
        end
        n_cmp++;
        if (lat !== LAT) begin
            n_bad++;
            $display("FAIL ignore_start_latency: got %0d want %0d", lat, LAT);
        end
        extra = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL ignore_start_no_second_op: %0d active cycles seen, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eqa, era, eqb, erb;
        int lat;
        model(1'b1, 32'hFFFFFC18, 32'd7, eqa, era);      // -1000 / 7
        model(1'b0, 32'hDEADBEEF, 32'h1234, eqb, erb);
        @(negedge clk);
        sgn = 1'b1; src1 = 32'hFFFFFC18; src2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (quotient !== eqa || remainder !== era || lat !== LAT) begin
            n_bad++;
            $display("FAIL b2b_first: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                     quotient, remainder, lat, eqa, era, LAT);
        end
        sgn = 1'b0; src1 = 32'hDEADBEEF; src2 = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept: busy=%b after done-cycle start, want 1", busy);
        end
        n_cmp++;
        if (quotient !== eqa) begin
            n_bad++;
            $display("FAIL b2b_hold: q=%h during second op, want %h", quotient, eqa);
        end
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (quotient !== eqb || remainder !== erb || lat !== LAT) begin
            n_bad++;
            $display("FAIL b2b_second: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                     quotient, remainder, lat, eqb, erb, LAT);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        int lat, bcyc, dones;
        @(negedge clk);
        sgn = 1'b0; src1 = 32'd999999; src2 = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_clear: busy=%b done=%b q=%h r=%h want all 0", busy, done, quotient, remainder);
        end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_done: %0d active cycles after reset, want 0", dones);
        end
        do_op(1'b0, 32'd1000, 32'd10, q, r, lat, bcyc);
        n_cmp++;
        if (q !== 32'd100 || r !== 32'd0 || lat !== LAT) begin
            n_bad++;
            $display("FAIL reset_mid_recover: got q=%0d r=%0d lat=%0d want q=100 r=0 lat=%0d", q, r, lat, LAT);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
